// File: rtl/fft_bitrev_loader.sv
// Bit-reversed frame loader feeding the radix-2 DIT input butterfly.
// Define DOUBLE_BUFFER_EN for ping-pong banks (fill overlaps drain).
module fft_bitrev_loader #(
  parameter int N         = 32,
  parameter int word_size = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 in_valid,
  input  logic [word_size-1:0] sample_in,
  output logic                 in_ready,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [word_size-1:0] sample1,
  output logic [word_size-1:0] sample2,
  output logic                 frame_done
);

  localparam int AW = $clog2(N);

  typedef enum logic [1:0] {
    FILL,
    LOAD,
    DRAIN
  } state_t;

  state_t state_q, state_d;

  logic [AW-1:0] wr_cnt;
  logic [AW-2:0] rd_cnt;
  logic [AW-2:0] rd_pair;
  logic          accept;
  logic          fire;
  logic          last_wr;
  logic          last_rd;

  function automatic logic [AW-1:0] bitrev(input logic [AW-1:0] a);
    for (int i = 0; i < AW; i++) bitrev[i] = a[AW-1-i];
  endfunction

`ifdef DOUBLE_BUFFER_EN
  localparam int MW = AW + 1;
  logic fill_bank;
  logic fill_full;
  logic fill_go;
  logic swap;
`else
  localparam int MW = AW;
`endif

  logic [word_size-1:0] mem [2**MW];
  logic [MW-1:0]        wr_addr;
  logic [MW-1:0]        rd_addr0;
  logic [MW-1:0]        rd_addr1;

  assign accept  = in_valid & in_ready;
  assign fire    = out_valid & out_ready;
  assign last_wr = accept && (wr_cnt == '1);
  assign last_rd = fire && (rd_cnt == '1);
  assign rd_pair = (state_q == LOAD) ? '0 : rd_cnt + 1'b1;

`ifdef DOUBLE_BUFFER_EN
  // A completed fill bank waits here until the drain side goes idle.
  assign fill_go  = fill_full | last_wr;
  assign swap     = (state_q == FILL) && fill_go;
  assign in_ready = ~fill_full;
  assign wr_addr  = {fill_bank, bitrev(wr_cnt)};
  assign rd_addr0 = {~fill_bank, rd_pair, 1'b0};
  assign rd_addr1 = {~fill_bank, rd_pair, 1'b1};
`else
  assign in_ready = (state_q == FILL);
  assign wr_addr  = bitrev(wr_cnt);
  assign rd_addr0 = {rd_pair, 1'b0};
  assign rd_addr1 = {rd_pair, 1'b1};
`endif

  always_ff @(posedge clk) begin
    if (reset) state_q <= FILL;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
`ifdef DOUBLE_BUFFER_EN
      FILL:  if (swap) state_d = LOAD;
`else
      FILL:  if (last_wr) state_d = LOAD;
`endif
      LOAD:  state_d = DRAIN;
      DRAIN: if (last_rd) state_d = FILL;
      default: state_d = FILL;
    endcase
  end

  always_ff @(posedge clk) begin
    if (accept) mem[wr_addr] <= sample_in;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_cnt     <= '0;
      rd_cnt     <= '0;
      out_valid  <= 1'b0;
      sample1    <= '0;
      sample2    <= '0;
      frame_done <= 1'b0;
`ifdef DOUBLE_BUFFER_EN
      fill_bank  <= 1'b0;
      fill_full  <= 1'b0;
`endif
    end else begin
      frame_done <= 1'b0;
      if (accept) wr_cnt <= wr_cnt + 1'b1;
`ifdef DOUBLE_BUFFER_EN
      if (swap) begin
        fill_bank <= ~fill_bank;
        fill_full <= 1'b0;
      end else if (last_wr) begin
        fill_full <= 1'b1;
      end
`endif
      // Next pair is fetched on the handshake edge itself: 1 pair/cycle.
      if (state_q == LOAD) begin
        sample1   <= mem[rd_addr0];
        sample2   <= mem[rd_addr1];
        out_valid <= 1'b1;
        rd_cnt    <= '0;
      end else if (state_q == DRAIN && fire) begin
        if (last_rd) begin
          out_valid  <= 1'b0;
          frame_done <= 1'b1;
          rd_cnt     <= '0;
        end else begin
          rd_cnt  <= rd_cnt + 1'b1;
          sample1 <= mem[rd_addr0];
          sample2 <= mem[rd_addr1];
        end
      end
    end
  end

endmodule

// File: tb/tb_fft_bitrev_loader.sv
// Directed + randomized bench for fft_bitrev_loader (N=8),
// checked against a bit-reversal reference model.
module tb_fft_bitrev_loader;

  localparam int N = 8;
  localparam int W = 16;
  localparam int LOGN = 3;

  logic         clk = 1'b0;
  logic         reset;
  logic         in_valid;
  logic [W-1:0] sample_in;
  logic         in_ready;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] sample1;
  logic [W-1:0] sample2;
  logic         frame_done;

  int checks = 0;
  int errors = 0;
  int xin [N];
  int e1 [N/2];
  int e2 [N/2];

  always #5 clk = ~clk;

  fft_bitrev_loader #(.N(N), .word_size(W)) dut (
    .clk(clk),
    .reset(reset),
    .in_valid(in_valid),
    .sample_in(sample_in),
    .in_ready(in_ready),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .sample1(sample1),
    .sample2(sample2),
    .frame_done(frame_done)
  );

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  function automatic int brev(input int i);
    int r = 0;
    for (int b = 0; b < LOGN; b++) r = r * 2 + ((i / (1 << b)) % 2);
    return r;
  endfunction

  // Sample x[i] lands at address brev(i); pair k reads addresses 2k, 2k+1.
  task automatic set_exp;
    for (int k = 0; k < N/2; k++) begin
      e1[k] = xin[brev(2*k)];
      e2[k] = xin[brev(2*k+1)];
    end
  endtask

  task automatic rand_frame;
    for (int i = 0; i < N; i++) xin[i] = $urandom_range(0, 65535);
    set_exp();
  endtask

  task automatic do_reset;
    reset = 1'b1;
    in_valid = 1'b0;
    out_ready = 1'b0;
    sample_in = '0;
    tick();
    tick();
    check("rst_in_ready", in_ready, 1);
    check("rst_out_valid", out_valid, 0);
    check("rst_sample1", sample1, 0);
    check("rst_sample2", sample2, 0);
    check("rst_frame_done", frame_done, 0);
    reset = 1'b0;
  endtask

  task automatic feed(input int n, input bit gaps);
    for (int i = 0; i < n; i++) begin
      if (gaps && $urandom_range(0, 3) == 0) begin
        in_valid = 1'b0;
        tick();
      end
      check("fill_in_ready", in_ready, 1);
      in_valid = 1'b1;
      sample_in = W'(xin[i]);
      tick();
    end
    in_valid = 1'b0;
    if (n == N) begin
      check("lat_load_out_valid", out_valid, 0);
`ifndef DOUBLE_BUFFER_EN
      check("load_in_ready", in_ready, 0);
`endif
    end
  endtask

  // mode 0: ready=1, 1: stall 5 cycles, 2: toggle 1,0,..., 3: random
  task automatic drain(input int mode, input bit inject);
    int idx = 0;
    int hs = 0;
    int cyc = 0;
    bit fire = 1'b0;
    bit done = 1'b0;
    out_ready = (mode == 0) || (mode == 3 && $urandom_range(0, 1) == 1);
    if (inject) begin
      in_valid = 1'b1;
      sample_in = W'(99);
    end
    while (!done && cyc < 40) begin
      tick();
      cyc++;
      if (fire) begin
        hs++;
        idx++;
      end
      if (idx == N/2) begin
        check("last_frame_done", frame_done, 1);
        check("last_out_valid", out_valid, 0);
        done = 1'b1;
      end else begin
        check("pair_valid", out_valid, 1);
        check("pair_sample1", sample1, e1[idx]);
        check("pair_sample2", sample2, e2[idx]);
        check("pair_frame_done", frame_done, 0);
`ifndef DOUBLE_BUFFER_EN
        check("drain_in_ready", in_ready, 0);
`endif
        case (mode)
          0: out_ready = 1'b1;
          1: out_ready = (cyc > 5);
          2: out_ready = (cyc % 2 == 1);
          default: out_ready = ($urandom_range(0, 2) != 0);
        endcase
        fire = out_valid && out_ready;
      end
    end
    in_valid = 1'b0;
    check("drain_finished", done, 1);
    check("drain_handshakes", hs, N/2);
    if (mode == 0) check("drain_cycles", cyc, N/2 + 1);
    tick();
    check("post_frame_done", frame_done, 0);
    check("post_out_valid", out_valid, 0);
    check("post_in_ready", in_ready, 1);
  endtask

  initial begin
    do_reset();

    for (int i = 0; i < N; i++) xin[i] = i;
    set_exp();
    check("model_pair0", e2[0], 4);
    feed(N, 1'b0);
    drain(0, 1'b0);

    feed(N, 1'b0);
    drain(1, 1'b1);

    rand_frame();
    feed(N, 1'b1);
    drain(3, 1'b0);

    rand_frame();
    feed(5, 1'b1);
    do_reset();
    for (int i = 0; i < N; i++) xin[i] = 10 + i;
    set_exp();
    feed(N, 1'b0);
    drain(3, 1'b0);

    rand_frame();
    feed(N, 1'b0);
    drain(2, 1'b0);

    for (int f = 0; f < 4; f++) begin
      rand_frame();
      feed(N, 1'b1);
      drain(3, 1'b0);
    end

`ifdef DOUBLE_BUFFER_EN
    begin
      int got1 [$];
      int got2 [$];
      int i = 0;
      int cyc = 0;
      do_reset();
      out_ready = 1'b1;
      while ((i < 2*N || got1.size() < N) && cyc < 80) begin
        if (out_valid) begin
          got1.push_back(int'(sample1));
          got2.push_back(int'(sample2));
        end
        if (i < 2*N) begin
          check("db_in_ready", in_ready, 1);
          in_valid = 1'b1;
          sample_in = W'(i);
          i++;
        end else begin
          in_valid = 1'b0;
        end
        tick();
        cyc++;
      end
      in_valid = 1'b0;
      check("db_pair_count", got1.size(), N);
      for (int fr = 0; fr < 2; fr++) begin
        for (int k = 0; k < N; k++) xin[k] = fr * N + k;
        set_exp();
        for (int k = 0; k < N/2; k++) begin
          if (fr*(N/2) + k < got1.size()) begin
            check("db_sample1", got1[fr*(N/2)+k], e1[k]);
            check("db_sample2", got2[fr*(N/2)+k], e2[k]);
          end
        end
      end
    end
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
